// File: rtl/pc_ras_if.sv
// Control/status bundle between the picoMIPS controller/decoder and pc_ras.
// The controller drives the strobes and targets; pc_ras returns PC and stack status.
interface pc_ras_if #(
   parameter int Psize = 6,
   parameter int Osize = 4
);
   logic             Stall;
   logic             PCincr;
   logic             PCabsbranch;
   logic             PCrelbranch;
   logic             PCcall;
   logic             PCret;
   logic [Psize-1:0] Branchaddr;
   logic [Osize-1:0] Reloffset;
   logic [Psize-1:0] PCout;
   logic [Psize-1:0] RetAddr;
   logic             Full;
   logic             Empty;
   logic             StackErr;

   modport master (
      output Stall, PCincr, PCabsbranch, PCrelbranch, PCcall, PCret,
      output Branchaddr, Reloffset,
      input  PCout, RetAddr, Full, Empty, StackErr
   );

   modport slave (
      input  Stall, PCincr, PCabsbranch, PCrelbranch, PCcall, PCret,
      input  Branchaddr, Reloffset,
      output PCout, RetAddr, Full, Empty, StackErr
   );
endinterface

// File: rtl/pc_ras.sv
// picoMIPS program counter with call/return stack and sticky stack-error flag.
// Relative branch exists only when PICOMIPS_PC_RELBRANCH_EN is defined.
module pc_ras #(
   parameter int Psize = 6,
   parameter int Osize = 4,
   parameter int Depth = 4
) (
   input logic   clk,
   input logic   reset,
   pc_ras_if.slave bus
);
   localparam int CW = $clog2(Depth + 1);
   localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;

   logic [Psize-1:0] pc, pc_n, pc_inc;
   logic [CW-1:0]    cnt, cnt_n;
   logic             err, err_n;
   logic             push, full, empty;
   logic [AW-1:0]    top_idx, push_idx;
   logic [Psize-1:0] stk [Depth];
   logic [Psize-1:0] top;

   assign full     = (cnt == CW'(Depth));
   assign empty    = (cnt == '0);
   assign top_idx  = AW'(cnt - CW'(1));
   assign push_idx = AW'(cnt);
   assign top      = stk[top_idx];
   assign pc_inc   = pc + Psize'(1);

`ifdef PICOMIPS_PC_RELBRANCH_EN
   logic [Psize-1:0] rel_tgt;
   // Offset is applied to the current PC, sign-extended to PC width.
   assign rel_tgt = pc + Psize'($signed(bus.Reloffset));
`else
   logic unused_rel;
   assign unused_rel = &{1'b0, bus.PCrelbranch, bus.Reloffset};
`endif

   always_comb begin
      pc_n  = pc;
      cnt_n = cnt;
      err_n = err;
      push  = 1'b0;
      if (!bus.Stall) begin
         if (bus.PCcall) begin
            pc_n = bus.Branchaddr;
            if (full) begin
               err_n = 1'b1;
            end else begin
               push  = 1'b1;
               cnt_n = cnt + CW'(1);
            end
         end else if (bus.PCret) begin
            if (empty) begin
               err_n = 1'b1;
            end else begin
               pc_n  = top;
               cnt_n = cnt - CW'(1);
            end
         end else if (bus.PCabsbranch) begin
            pc_n = bus.Branchaddr;
`ifdef PICOMIPS_PC_RELBRANCH_EN
         end else if (bus.PCrelbranch) begin
            pc_n = rel_tgt;
`endif
         end else if (bus.PCincr) begin
            pc_n = pc_inc;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc  <= '0;
         cnt <= '0;
         err <= 1'b0;
      end else begin
         pc  <= pc_n;
         cnt <= cnt_n;
         err <= err_n;
      end
   end

   // Entries need no reset; RetAddr is masked while the stack is empty.
   always_ff @(posedge clk) begin
      if (push) stk[push_idx] <= pc_inc;
   end

   assign bus.PCout    = pc;
   assign bus.RetAddr  = empty ? '0 : top;
   assign bus.Full     = full;
   assign bus.Empty    = empty;
   assign bus.StackErr = err;
endmodule
